mat_mem_arbiter: RTL and testbench
==================================

# mat_mem_arbiter

Round-robin arbiter for the single-port matrix storage RAM, shared by four requesters: 0 = manual input, 1 = random generator, 2 = display formatter, 3 = operation unit. It grants one requester at a time for a burst, forwards that requester's access to the RAM, and returns read data tagged to the requester that issued the read. A watchdog reclaims the RAM from a requester that holds it too long. The block sits between the mode datapaths sequenced by the top-level control FSM and the storage RAM.

## Interface
Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- MAX_HOLD, 1024, maximum consecutive grant cycles before forced release (≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_i  in  4  per-requester request; held high for the whole burst
- we_i  in  4  per-requester write enable, sampled on access cycles
- addr_i  in  4*ADDR_W  requester k address at [k*ADDR_W +: ADDR_W]
- wdata_i  in  4*DATA_W  requester k write data at [k*DATA_W +: DATA_W]
- gnt_o  out  4  one-hot grant (registered)
- rvalid_o  out  4  one-cycle pulse: rdata_o belongs to requester k
- rdata_o  out  DATA_W  read data, a registered copy of mem_rdata
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read with mem_en
- busy_o  out  1  high while any grant is active
- hold_err_o  out  1  one-cycle pulse on watchdog release

## Operation
- States: IDLE (no grant) and OWN (one gnt_o bit high).
- IDLE: if any eligible req_i bit is high, select the first eligible index after last_gnt in circular order (last_gnt+1, +2, +3, +4 mod 4). Register that bit into gnt_o, set last_gnt to that index, clear hold_cnt, and go to OWN.
- Reset value of last_gnt is 3, so requester 0 has highest priority first.
- OWN, with k the granted index: every cycle with req_i[k]=1 is an access cycle. On an access cycle, mem_en=1, mem_we=we_i[k], mem_addr=addr_i[k], mem_wdata=wdata_i[k]; these paths are combinational from the inputs through gnt_o.
- Outside access cycles, mem_en=0, mem_we=0, and mem_addr/mem_wdata=0.
- OWN release: when req_i[k]=0, clear gnt_o and go to IDLE with no access that cycle. The next arbitration happens in IDLE, so there is one dead cycle between bursts.
- Watchdog: hold_cnt increments on each OWN access cycle, saturating at MAX_HOLD. When hold_cnt = MAX_HOLD-1 and the cycle is an access cycle, that access completes and the grant is then forced off. On that edge, hold_err_o pulses and blocked[k] is set.
- blocked[k] makes requester k ineligible until req_i[k] is seen low, which clears it.
- Read return: on a read access, the issuing index is latched as rd_pend/rd_idx. One cycle later, rdata_o<=mem_rdata and rvalid_o[rd_idx] pulses on the following edge. This return happens even if the grant has been released meanwhile.
- Only one outstanding read stage exists. Back-to-back reads stream one result per cycle.
- Simultaneous events in the same cycle: release and a new request from another index cannot be granted that cycle (the dead cycle applies). A forced release and a fresh req from the same index leave it blocked.

## Timing
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, busy_o=0, hold_err_o=0, mem_* outputs=0, last_gnt=3, blocked=0, hold_cnt=0, rd_pend=0.
- Reset asserted mid-burst: the grant is dropped immediately, and any pending rvalid_o is discarded.
- Grant latency: req_i rises in cycle n (state IDLE) → gnt_o high in cycle n+1. The first access is in cycle n+1 if req_i is still high.
- Read latency: access in cycle a → mem_rdata valid in a+1 → rvalid_o/rdata_o valid in a+2.
- busy_o equals OR of gnt_o, registered.
- hold_err_o is high for exactly one cycle, the cycle after the final allowed access.
- Max grants per burst is MAX_HOLD accesses.

## Test plan
- Single requester 2 reads addr 0x05 (RAM holds 0xA7) → gnt_o=0100 one cycle after req; rvalid_o=0100 with rdata_o=0xA7 two cycles after the access.
- All four req_i rise together from reset, each holding a 3-cycle burst → grants in order 0,1,2,3, with one dead cycle between bursts and exactly 3 mem_en cycles per burst.
- After requester 1 finishes, with 0 and 3 pending → 3 is granted before 0.
- Requester 0 writes 0x11..0x14 to addr 0..3, then requester 3 reads addr 0..3 back-to-back → four consecutive rvalid_o=1000 pulses carrying 0x11..0x14.
- MAX_HOLD=4 and requester 1 holds req for 10 cycles → 4 accesses, then hold_err_o pulses and gnt_o=0. Requester 1 is not regranted until req_i[1] drops, while requester 2 pending is granted next.
- rst_n asserted mid-burst with a read in flight → all outputs 0 immediately and no rvalid_o afterwards. After release, requester 0 is granted first.

Source files
------------

// File: rtl/mat_mem_arbiter.sv
// Round-robin arbiter for the shared single-port matrix RAM.
// Four requesters, burst grants, tagged read return, hold watchdog.
module mat_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req_i,
  input  logic [3:0]            we_i,
  input  logic [4*ADDR_W-1:0]   addr_i,
  input  logic [4*DATA_W-1:0]   wdata_i,
  output logic [3:0]            gnt_o,
  output logic [3:0]            rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy_o,
  output logic                  hold_err_o
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_gnt;
  logic [3:0]        w_gnt_nxt;
  logic [1:0]        r_last;
  logic [1:0]        w_last_nxt;
  logic [1:0]        w_idx;
  logic [3:0]        r_blocked;
  logic [3:0]        w_blocked_nxt;
  logic [3:0]        w_elig;
  logic [CW-1:0]     r_hold_cnt;
  logic [CW-1:0]     w_hold_nxt;
  logic              w_force;
  logic              w_found;
  logic              r_busy;
  logic              r_hold_err;
  logic              r_rd_pend;
  logic [1:0]        r_rd_idx;
  logic [3:0]        r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  // Forward the owner's access to the RAM while it keeps requesting.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      if (r_gnt[k] && req_i[k]) begin
        mem_en    = 1'b1;
        mem_we    = we_i[k];
        mem_addr  = addr_i[k*ADDR_W +: ADDR_W];
        mem_wdata = wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Arbitration, release and watchdog next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold_cnt;
    w_force     = 1'b0;
    w_found     = 1'b0;
    w_idx       = '0;
    w_elig      = req_i & ~r_blocked;
    unique case (r_state)
      IDLE: begin
        for (int i = 1; i <= 4; i++) begin
          w_idx = r_last + 2'(i);
          if (!w_found && w_elig[w_idx]) begin
            w_found     = 1'b1;
            w_last_nxt  = w_idx;
            w_gnt_nxt   = 4'b0001 << w_idx;
            w_hold_nxt  = '0;
            w_state_nxt = OWN;
          end
        end
      end
      OWN: begin
        if (!mem_en) begin
          w_gnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          if (r_hold_cnt != CW'(MAX_HOLD))
            w_hold_nxt = r_hold_cnt + CW'(1);
          if (r_hold_cnt == CW'(MAX_HOLD - 1)) begin
            w_force     = 1'b1;
            w_gnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end
      end
    endcase
    w_blocked_nxt = (r_blocked & req_i) | ({4{w_force}} & r_gnt);
  end

  // State and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_last     <= 2'd3;
      r_hold_cnt <= '0;
      r_blocked  <= '0;
      r_busy     <= 1'b0;
      r_hold_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_blocked  <= w_blocked_nxt;
      r_busy     <= |w_gnt_nxt;
      r_hold_err <= w_force;
    end
  end

  // Read return pipe: tag the read, then capture RAM data a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_rd_idx  <= '0;
      r_rvalid  <= '0;
      r_rdata   <= '0;
    end else begin
      r_rd_pend <= mem_en & ~mem_we;
      if (mem_en && !mem_we)
        r_rd_idx <= r_last;
      r_rvalid <= r_rd_pend ? (4'b0001 << r_rd_idx) : 4'b0000;
      if (r_rd_pend)
        r_rdata <= mem_rdata;
    end
  end

  assign gnt_o      = r_gnt;
  assign busy_o     = r_busy;
  assign hold_err_o = r_hold_err;
  assign rvalid_o   = r_rvalid;
  assign rdata_o    = r_rdata;

endmodule

// File: tb/tb_mat_mem_arbiter.sv
// Directed self-checking bench for mat_mem_arbiter.
// Uses MAX_HOLD=4 and a behavioural one-cycle-latency RAM.
module tb_mat_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [7:0]  ta [4];
  logic [7:0]  tw [4];
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  gnt_o;
  logic [3:0]  rvalid_o;
  logic [7:0]  rdata_o;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy_o;
  logic        hold_err_o;
  logic [7:0]  ram [256];

  int n_chk = 0;
  int n_err = 0;

  assign addr_i  = {ta[3], ta[2], ta[1], ta[0]};
  assign wdata_i = {tw[3], tw[2], tw[1], tw[0]};

  mat_mem_arbiter #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .MAX_HOLD(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .we_i      (we),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy_o    (busy_o),
    .hold_err_o(hold_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    we    = '0;
    for (int k = 0; k < 4; k++) begin
      ta[k] = '0;
      tw[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++;
    if ({gnt_o, rvalid_o, busy_o, hold_err_o} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 0",
               {gnt_o, rvalid_o, busy_o, hold_err_o});
    end
    n_chk++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, rdata_o} !== 26'b0) begin
      n_err++;
      $display("FAIL reset_mem: got %h want 0",
               {mem_en, mem_we, mem_addr, mem_wdata, rdata_o});
    end
    tick();
  endtask

  task automatic test_single_read();
    req = 4'b0100; we = '0; ta[2] = 8'h05;
    #1;
    n_chk++;
    if (gnt_o !== 4'b0000) begin
      n_err++; $display("FAIL sr_gnt0: got %b want 0000", gnt_o);
    end
    tick(); #1;
    n_chk++;
    if ({gnt_o, busy_o, mem_en, mem_we, mem_addr} !== {4'b0100, 3'b110, 8'h05}) begin
      n_err++;
      $display("FAIL sr_access: got g=%b b=%b en=%b we=%b a=%h want g=0100 b=1 en=1 we=0 a=05",
               gnt_o, busy_o, mem_en, mem_we, mem_addr);
    end
    tick();
    req = '0;
    #1;
    n_chk++;
    if ({mem_en, rvalid_o} !== 5'b0) begin
      n_err++; $display("FAIL sr_release: got en=%b rv=%b want 0", mem_en, rvalid_o);
    end
    tick(); #1;
    n_chk++;
    if ({rvalid_o, rdata_o} !== {4'b0100, 8'hA7}) begin
      n_err++; $display("FAIL sr_rdata: got rv=%b d=%h want rv=0100 d=a7", rvalid_o, rdata_o);
    end
    tick(); #1;
    n_chk++;
    if ({rvalid_o, gnt_o, busy_o} !== 9'b0) begin
      n_err++; $display("FAIL sr_after: got rv=%b g=%b b=%b want 0", rvalid_o, gnt_o, busy_o);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int cnt [4];
    logic [3:0] eg;
    logic       een;
    int p;
    int r;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0;
      ta[k]  = 8'h10 + 8'(k);
    end
    for (int c = 0; c < 22; c++) begin
      for (int k = 0; k < 4; k++) req[k] = (c < 4 + 5 * k);
      #1;
      eg  = '0;
      een = 1'b0;
      if (c > 0) begin
        p = (c - 1) / 5;
        r = (c - 1) % 5;
        if (p < 4 && r < 4) eg = 4'b0001 << p;
        if (p < 4 && r < 3) een = 1'b1;
      end
      n_chk++;
      if ({gnt_o, mem_en} !== {eg, een}) begin
        n_err++;
        $display("FAIL rr_cyc%0d: got g=%b en=%b want g=%b en=%b", c, gnt_o, mem_en, eg, een);
      end
      if (mem_en)
        for (int k = 0; k < 4; k++)
          if (gnt_o[k]) begin
            cnt[k]++;
            n_chk++;
            if (mem_addr !== 8'h10 + 8'(k)) begin
              n_err++; $display("FAIL rr_addr%0d: got %h want %h", k, mem_addr, 8'h10 + 8'(k));
            end
          end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (cnt[k] !== 3) begin
        n_err++; $display("FAIL rr_bursts%0d: got %0d want 3", k, cnt[k]);
      end
    end
  endtask

  task automatic test_rr_order();
    req = 4'b0010; tick();
    req = 4'b1011; #1;
    n_chk++;
    if (gnt_o !== 4'b0010) begin
      n_err++; $display("FAIL ord_g1: got %b want 0010", gnt_o);
    end
    tick();
    req = 4'b1001; tick(); #1;
    n_chk++;
    if (gnt_o !== 4'b0000) begin
      n_err++; $display("FAIL ord_dead: got %b want 0000", gnt_o);
    end
    tick(); #1;
    n_chk++;
    if ({gnt_o, mem_en} !== 5'b10001) begin
      n_err++; $display("FAIL ord_g3: got g=%b en=%b want g=1000 en=1", gnt_o, mem_en);
    end
    tick();
    req = 4'b0001; tick(); tick(); #1;
    n_chk++;
    if (gnt_o !== 4'b0001) begin
      n_err++; $display("FAIL ord_g0: got %b want 0001", gnt_o);
    end
    tick();
    req = '0; tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] erv;
    req = 4'b0001; we = 4'b0001; ta[0] = '0; tw[0] = 8'h11;
    tick();
    for (int i = 0; i < 4; i++) begin
      ta[0] = 8'(i);
      tw[0] = 8'h11 + 8'(i);
      #1;
      n_chk++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'(i), 8'h11 + 8'(i)}) begin
        n_err++;
        $display("FAIL wr%0d: got en=%b we=%b a=%h d=%h want en=1 we=1 a=%h d=%h",
                 i, mem_en, mem_we, mem_addr, mem_wdata, 8'(i), 8'h11 + 8'(i));
      end
      tick();
    end
    req = '0; we = '0;
    #1;
    n_chk++;
    if ({hold_err_o, gnt_o} !== 5'b10000) begin
      n_err++; $display("FAIL wr_release: got he=%b g=%b want he=1 g=0000", hold_err_o, gnt_o);
    end
    tick();
    req = 4'b1000; ta[3] = '0;
    tick();
    for (int c = 7; c < 15; c++) begin
      req = (c <= 10) ? 4'b1000 : 4'b0000;
      if (c <= 10) ta[3] = 8'(c - 7);
      #1;
      erv = (c >= 9 && c <= 12) ? 4'b1000 : 4'b0000;
      n_chk++;
      if (rvalid_o !== erv) begin
        n_err++; $display("FAIL b2b_rv_c%0d: got %b want %b", c, rvalid_o, erv);
      end
      if (c >= 9 && c <= 12) begin
        n_chk++;
        if (rdata_o !== 8'h11 + 8'(c - 9)) begin
          n_err++; $display("FAIL b2b_rd_c%0d: got %h want %h", c, rdata_o, 8'h11 + 8'(c - 9));
        end
      end
      tick();
    end
  endtask

  task automatic test_watchdog();
    logic [3:0] eg [0:14];
    int acc1;
    eg = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4,
           4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0};
    acc1 = 0;
    we = '0; ta[1] = 8'h30; ta[2] = 8'h31;
    for (int c = 0; c < 15; c++) begin
      req[1] = (c <= 9) || (c == 11) || (c == 12);
      req[2] = (c >= 2) && (c <= 6);
      req[0] = 1'b0;
      req[3] = 1'b0;
      #1;
      n_chk++;
      if (gnt_o !== eg[c]) begin
        n_err++; $display("FAIL wd_gnt_c%0d: got %b want %b", c, gnt_o, eg[c]);
      end
      n_chk++;
      if (hold_err_o !== (c == 5)) begin
        n_err++; $display("FAIL wd_herr_c%0d: got %b want %b", c, hold_err_o, (c == 5));
      end
      if (c <= 10 && mem_en && gnt_o[1]) acc1++;
      tick();
    end
    n_chk++;
    if (acc1 !== 4) begin
      n_err++; $display("FAIL wd_accesses: got %0d want 4", acc1);
    end
  endtask

  task automatic test_reset_midburst();
    req = 4'b0100; we = '0; ta[2] = 8'h05; ta[0] = 8'h02;
    tick(); tick();
    rst_n = 1'b0;
    req   = 4'b0101;
    #1;
    n_chk++;
    if ({gnt_o, busy_o, mem_en, mem_addr, rvalid_o, rdata_o, hold_err_o} !== 27'b0) begin
      n_err++;
      $display("FAIL rst_mid: got g=%b b=%b en=%b a=%h rv=%b d=%h he=%b want 0",
               gnt_o, busy_o, mem_en, mem_addr, rvalid_o, rdata_o, hold_err_o);
    end
    tick(); #1;
    n_chk++;
    if (rvalid_o !== 4'b0000) begin
      n_err++; $display("FAIL rst_rv1: got %b want 0000", rvalid_o);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_chk++;
    if ({gnt_o, rvalid_o} !== 8'b0) begin
      n_err++; $display("FAIL rst_rv2: got g=%b rv=%b want 0", gnt_o, rvalid_o);
    end
    tick(); #1;
    n_chk++;
    if ({gnt_o, rvalid_o} !== 8'b00010000) begin
      n_err++; $display("FAIL rst_first: got g=%b rv=%b want g=0001 rv=0000", gnt_o, rvalid_o);
    end
    tick();
    req = '0;
    #1;
    n_chk++;
    if (rvalid_o !== 4'b0000) begin
      n_err++; $display("FAIL rst_rv3: got %b want 0000", rvalid_o);
    end
    tick(); #1;
    n_chk++;
    if (rvalid_o !== 4'b0001) begin
      n_err++; $display("FAIL rst_rv4: got %b want 0001", rvalid_o);
    end
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[5] = 8'hA7;
    mem_rdata = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_rr_order();
    test_back_to_back();
    test_watchdog();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
